idu_stage: RTL and testbench

//  Decode stage directly downstream of the fetch unit. Accepts {pc, inst} over a valid/ready

---
 rtl/idu_stage.sv | 217 +++++++++++++++++++++
 tb/tb_idu_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// idu_stage: RV32I decode stage between fetch and execute, valid/ready on both sides.
// Define IDU_SKID_EN to add a one-entry skid register and a fully registered in_ready.
module idu_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_op_class,
  output logic            out_illegal,
  output logic            out_is_ebreak
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [3:0]      op_class;
    logic            illegal;
    logic            ebreak;
  } entry_t;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [3:0]  w_class;
  logic [31:0] w_imm32;
  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_bad_f3;
  logic        w_rv32e_bad;
  logic        w_illegal;
  entry_t      w_new;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];

  always_comb begin
    w_class   = 4'd15;
    w_imm32   = 32'd0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_bad_f3  = 1'b0;
    case (w_opcode)
      7'b0110111: begin
        w_class  = 4'd0;
        w_imm32  = {in_inst[31:12], 12'd0};
        w_use_rd = 1'b1;
      end
      7'b0010111: begin
        w_class  = 4'd1;
        w_imm32  = {in_inst[31:12], 12'd0};
        w_use_rd = 1'b1;
      end
      7'b1101111: begin
        w_class  = 4'd2;
        w_imm32  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        w_use_rd = 1'b1;
      end
      7'b1100111: begin
        w_class   = 4'd3;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      7'b1100011: begin
        w_class   = 4'd4;
        w_imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_bad_f3  = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
      end
      7'b0000011: begin
        w_class   = 4'd5;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_bad_f3  = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
      end
      7'b0100011: begin
        w_class   = 4'd6;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_bad_f3  = (w_funct3 >= 3'd3);
      end
      7'b0010011: begin
        w_class   = 4'd7;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      7'b0110011: begin
        w_class   = 4'd8;
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b1110011: begin
        w_class   = 4'd9;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      default: ;
    endcase
  end

  // RV32E only has x0..x15, so bit 4 of any register field the opcode reads or writes is illegal
  assign w_rv32e_bad = (REG_AW == 4) &&
                       ((w_use_rd & in_inst[11]) | (w_use_rs1 & in_inst[19]) | (w_use_rs2 & in_inst[24]));
  assign w_illegal   = (w_class == 4'd15) || w_bad_f3 || w_rv32e_bad;

  always_comb begin
    w_new          = '0;
    w_new.pc       = in_pc;
    w_new.inst     = in_inst;
    w_new.imm      = XLEN'($signed(w_imm32));
    w_new.op_class = w_illegal ? 4'd15 : w_class;
    w_new.illegal  = w_illegal;
    w_new.ebreak   = (in_inst == 32'h0010_0073);
  end

  entry_t r_main;
  logic   r_main_vld;
  logic   w_in_fire;
  logic   w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_vld & out_ready;

`ifdef IDU_SKID_EN
  entry_t r_skid;
  logic   r_skid_vld;
  logic   r_in_ready;
  logic   w_skid_vld_next;

  assign w_skid_vld_next = r_skid_vld ? (~w_out_fire | w_in_fire)
                                      : (w_in_fire & r_main_vld & ~w_out_fire);
  assign in_ready = r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main     <= '0;
      r_main_vld <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_out_fire) begin
        // Skid always holds the younger entry, so it is promoted before any new capture
        if (r_skid_vld) begin
          r_main <= r_skid;
          if (w_in_fire) r_skid <= w_new;
        end else begin
          r_main_vld <= w_in_fire;
          if (w_in_fire) r_main <= w_new;
        end
      end else if (w_in_fire) begin
        if (r_main_vld) begin
          r_skid <= w_new;
        end else begin
          r_main     <= w_new;
          r_main_vld <= 1'b1;
        end
      end
      r_skid_vld <= w_skid_vld_next;
      r_in_ready <= ~w_skid_vld_next;
    end
  end
`else
  logic r_live;

  assign in_ready = r_live & (~r_main_vld | out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live     <= 1'b0;
      r_main     <= '0;
      r_main_vld <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_in_fire) begin
        r_main     <= w_new;
        r_main_vld <= 1'b1;
      end else if (w_out_fire) begin
        r_main_vld <= 1'b0;
      end
    end
  end
`endif

  assign out_valid     = r_main_vld;
  assign out_pc        = r_main.pc;
  assign out_inst      = r_main.inst;
  assign out_rs1       = r_main.inst[19:15];
  assign out_rs2       = r_main.inst[24:20];
  assign out_rd        = r_main.inst[11:7];
  assign out_imm       = r_main.imm;
  assign out_op_class  = r_main.op_class;
  assign out_illegal   = r_main.illegal;
  assign out_is_ebreak = r_main.ebreak;

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: directed cases plus random traffic against a queue model.
// A second instance with REG_AW=4 checks RV32E register legality on the same stream.
module tb_idu_stage;

`ifdef IDU_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_op_class;
  logic        out_illegal, out_is_ebreak;

  logic        e_in_ready, e_out_valid, e_out_illegal, e_out_is_ebreak;
  logic [31:0] e_out_pc, e_out_inst, e_out_imm;
  logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
  logic [3:0]  e_out_op_class;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32), .REG_AW(5)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_op_class(out_op_class), .out_illegal(out_illegal),
    .out_is_ebreak(out_is_ebreak)
  );

  idu_stage #(.XLEN(32), .REG_AW(4)) u_dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .out_inst(e_out_inst), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
    .out_imm(e_out_imm), .out_op_class(e_out_op_class), .out_illegal(e_out_illegal),
    .out_is_ebreak(e_out_is_ebreak)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [3:0] cls; logic ill; logic [31:0] imm; } dec_t;

  ent_t        q[$];
  logic [31:0] drained[$];
  bit          live = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode built from the ISA field definitions using shifts and signed arithmetic
  function automatic dec_t ref_decode(input logic [31:0] w, input bit rv32e);
    dec_t d;
    int s;
    logic [31:0] u;
    logic [2:0] f3;
    bit bad, urd, urs1, urs2;
    s = $signed(w);
    f3 = w[14:12];
    u = 0; bad = 0; urd = 0; urs1 = 0; urs2 = 0;
    d.cls = 4'd15;
    case (w[6:0])
      7'h37: begin d.cls = 0; u = w & 32'hFFFF_F000; urd = 1; end
      7'h17: begin d.cls = 1; u = w & 32'hFFFF_F000; urd = 1; end
      7'h6F: begin
        d.cls = 2; urd = 1;
        u = (((w >> 21) & 32'h3FF) << 1) | (((w >> 20) & 32'h1) << 11) | (((w >> 12) & 32'hFF) << 12);
        if (w[31]) u = u - 32'h0010_0000;
      end
      7'h67: begin d.cls = 3; u = s >>> 20; urd = 1; urs1 = 1; end
      7'h63: begin
        d.cls = 4; urs1 = 1; urs2 = 1; bad = (f3 == 2) || (f3 == 3);
        u = (((w >> 8) & 32'hF) << 1) | (((w >> 25) & 32'h3F) << 5) | (((w >> 7) & 32'h1) << 11);
        if (w[31]) u = u - 32'h0000_1000;
      end
      7'h03: begin d.cls = 5; u = s >>> 20; urd = 1; urs1 = 1; bad = (f3 == 3) || (f3 >= 6); end
      7'h23: begin
        d.cls = 6; urs1 = 1; urs2 = 1; bad = (f3 >= 3);
        u = ((w >> 7) & 32'h1F) | (((w >> 25) & 32'h3F) << 5);
        if (w[31]) u = u - 32'h0000_0800;
      end
      7'h13: begin d.cls = 7; u = s >>> 20; urd = 1; urs1 = 1; end
      7'h33: begin d.cls = 8; u = 0; urd = 1; urs1 = 1; urs2 = 1; end
      7'h73: begin d.cls = 9; u = s >>> 20; urd = 1; urs1 = 1; end
      default: d.cls = 4'd15;
    endcase
    d.ill = (d.cls == 4'd15) || bad ||
            (rv32e && ((urd && w[11]) || (urs1 && w[19]) || (urs2 && w[24])));
    if (d.ill) d.cls = 4'd15;
    d.imm = u;
    return d;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    logic [6:0] opc;
    w = $urandom();
    case ($urandom_range(0, 11))
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8: opc = 7'h33;  9: opc = 7'h73;  10: opc = 7'h0F; default: opc = 7'h7F;
    endcase
    w[6:0] = opc;
    if ($urandom_range(0, 2) == 0) begin w[11] = 0; w[19] = 0; w[24] = 0; end
    if ($urandom_range(0, 40) == 0) w = 32'h0010_0073;
    return w;
  endfunction

  // Called at a falling edge: apply inputs, check outputs against the model, clock once
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] inst, input bit ordy);
    bit exp_rdy, in_fire, out_fire;
    dec_t d, de;
    ent_t h;
    in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    exp_rdy = live && ((CAP == 1) ? (q.size() == 0 || ordy) : (q.size() < 2));
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("e_out_valid", {31'd0, e_out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      h = q[0];
      d = ref_decode(h.inst, 1'b0);
      de = ref_decode(h.inst, 1'b1);
      chk("out_pc", out_pc, h.pc);
      chk("out_inst", out_inst, h.inst);
      chk("out_rs1", {27'd0, out_rs1}, (h.inst >> 15) & 32'h1F);
      chk("out_rs2", {27'd0, out_rs2}, (h.inst >> 20) & 32'h1F);
      chk("out_rd", {27'd0, out_rd}, (h.inst >> 7) & 32'h1F);
      chk("op_class", {28'd0, out_op_class}, {28'd0, d.cls});
      chk("illegal", {31'd0, out_illegal}, {31'd0, d.ill});
      chk("is_ebreak", {31'd0, out_is_ebreak}, {31'd0, h.inst == 32'h0010_0073});
      if (!d.ill) chk("out_imm", out_imm, d.imm);
      chk("e_op_class", {28'd0, e_out_op_class}, {28'd0, de.cls});
      chk("e_illegal", {31'd0, e_out_illegal}, {31'd0, de.ill});
    end
    in_fire  = iv && exp_rdy;
    out_fire = (q.size() != 0) && ordy;
    @(posedge clk);
    if (out_fire) begin
      h = q.pop_front();
      drained.push_back(h.pc);
      $display("xfer out pc=%h inst=%h class=%0d", h.pc, h.inst, ref_decode(h.inst, 1'b0).cls);
    end
    if (in_fire) begin
      q.push_back('{pc: pc, inst: inst});
      accepted++;
    end
    live = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc;
    int k;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1);

    step(1, 32'h0000_0100, 32'h0050_0093, 1);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_class", {28'd0, out_op_class}, 32'd7);
    chk("t1_rd", {27'd0, out_rd}, 32'd1);
    chk("t1_rs1", {27'd0, out_rs1}, 32'd0);
    chk("t1_imm", out_imm, 32'h5);
    chk("t1_illegal", {31'd0, out_illegal}, 32'd0);
    step(1, 32'h0000_0104, 32'hFE00_0EE3, 1);
    chk("t2_class", {28'd0, out_op_class}, 32'd4);
    chk("t2_imm", out_imm, 32'hFFFF_FFFC);
    step(1, 32'h0000_0108, 32'h0010_0073, 1);
    chk("t3_ebreak", {31'd0, out_is_ebreak}, 32'd1);
    chk("t3_class", {28'd0, out_op_class}, 32'd9);
    step(1, 32'h0000_010C, 32'h0000_007F, 1);
    chk("t4_class", {28'd0, out_op_class}, 32'd15);
    chk("t4_illegal", {31'd0, out_illegal}, 32'd1);
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Backpressure: three stalled cycles, then drain in order
    accepted = 0;
    drained.delete();
    k = 0;
    for (int c = 0; c < 3; c++) begin
      pc = 32'h8000_0000 + 32'(k * 4);
      step(1, pc, 32'h0000_0013 + 32'(k << 20), 0);
      k = accepted;
    end
    chk("stall_accepts", 32'(accepted), 32'(CAP));
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 12; c++) begin
      if (accepted < 3) begin
        pc = 32'h8000_0000 + 32'(accepted * 4);
        step(1, pc, 32'h0000_0013 + 32'(accepted << 20), 1);
      end else begin
        step(0, 0, 0, 1);
      end
    end
    chk("order_count", 32'(drained.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < drained.size()) chk("order_pc", drained[i], 32'h8000_0000 + 32'(i * 4));
    end

    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, gen_inst(),
           $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset with entries held
    step(1, 32'h0000_0200, 32'h0000_0033, 0);
    step(1, 32'h0000_0204, 32'h0000_0033, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_e_out_valid", {31'd0, e_out_valid}, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    q.delete();
    live = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step(1, 32'h0000_0300, 32'h0050_0093, 1);
    step(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
